// File: rtl/reg_file_pkg.sv
// Shared sizing, types and reset constant for the 8 x 16-bit general-purpose register file.
package reg_file_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_data_t RESET_VALUE = '0;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: select mux, optional write-through forward, en-gated output flop.
// Optional feature macro: REG_FILE_WRITE_BYPASS_EN (forward same-edge write data on a collision).
module reg_file_rd_port #(
  parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
`ifdef REG_FILE_WRITE_BYPASS_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] data
);
  import reg_file_pkg::*;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Hold when stalled; otherwise sample the selected register (or the in-flight write).
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = regs[sel];
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (wr_en && (wr_sel == sel)) begin
        data_d = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= DATA_W'(RESET_VALUE);
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/reg_file.sv
// 8 x 16-bit register file: one write port (D), two registered read ports (A, B), global stall enable.
// Optional feature macro: REG_FILE_WRITE_BYPASS_EN (read ports forward dataD on a select collision).
module reg_file #(
  parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] selA,
  input  logic [ADDR_W-1:0] selB,
  input  logic [ADDR_W-1:0] selD,
  input  logic [DATA_W-1:0] dataD,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB
);
  import reg_file_pkg::*;

  localparam int unsigned N_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic              wr_en;

  assign wr_en = en & we;

  // Write decode: only the selected register changes, and only when not stalled.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[selD] = dataD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_REGS); i++) begin
        regs_q[i] <= DATA_W'(RESET_VALUE);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sel     (selA),
    .regs    (regs_q),
`ifdef REG_FILE_WRITE_BYPASS_EN
    .wr_en   (wr_en),
    .wr_sel  (selD),
    .wr_data (dataD),
`endif
    .data    (dataA)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sel     (selB),
    .regs    (regs_q),
`ifdef REG_FILE_WRITE_BYPASS_EN
    .wr_en   (wr_en),
    .wr_sel  (selD),
    .wr_data (dataD),
`endif
    .data    (dataB)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed plan plus random traffic against an array model.
// Honours REG_FILE_WRITE_BYPASS_EN for collision expectations.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  selA = '0;
  logic [2:0]  selB = '0;
  logic [2:0]  selD = '0;
  logic [15:0] dataD = '0;
  logic [15:0] dataA;
  logic [15:0] dataB;

  logic [15:0] model_regs [8];
  logic [15:0] exp_a;
  logic [15:0] exp_b;
  bit          chk_on = 1'b0;
  int          checks = 0;
  int          errors = 0;

`ifdef REG_FILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .we    (we),
    .selA  (selA),
    .selB  (selB),
    .selD  (selD),
    .dataD (dataD),
    .dataA (dataA),
    .dataB (dataB)
  );

  always #5 clk = ~clk;

  // Model: reads see the pre-edge array (or dataD when forwarding), then the write lands.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
      exp_a = 16'h0000;
      exp_b = 16'h0000;
    end else if (en) begin
      exp_a = (BYPASS && we && selD == selA) ? dataD : model_regs[selA];
      exp_b = (BYPASS && we && selD == selB) ? dataD : model_regs[selB];
      if (we) model_regs[selD] = dataD;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic e, input logic w, input logic [2:0] sd,
                       input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] dd);
    rst = r; en = e; we = w; selD = sd; selA = sa; selB = sb; dataD = dd;
    tick();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
    end
  endtask

  // Every-cycle comparison against the model once reset has been applied.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_port_a", dataA, exp_a);
      chk("model_port_b", dataB, exp_b);
    end
  end

  initial begin
    // Reset for two cycles with random write traffic.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'b1, 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    chk_on = 1'b1;
    chk("reset_a", dataA, 16'h0000);
    chk("reset_b", dataB, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0, 3'(i), 3'(7 - i), 16'h0);
      chk("reset_read_all", dataA, 16'h0000);
    end

    // Basic write then a we=0 cycle that must not write.
    drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 3'd1, 16'hFFFF);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFEED);
    chk("basic_read0", dataA, 16'hFFFF);

    // Overwrite index 2.
    drive(1'b0, 1'b1, 1'b1, 3'd2, 3'd1, 3'd1, 16'h2222);
    drive(1'b0, 1'b1, 1'b1, 3'd2, 3'd1, 3'd1, 16'h3333);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd1, 16'h0);
    chk("overwrite2", dataA, 16'h3333);

    // Dual read.
    drive(1'b0, 1'b1, 1'b1, 3'd4, 3'd1, 3'd1, 16'h4444);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 3'd4, 16'h0);
    chk("dual_a4", dataA, 16'h4444);
    chk("dual_b4", dataB, 16'h4444);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd0, 16'h0);
    chk("dual_a2", dataA, 16'h3333);
    chk("dual_b0", dataB, 16'hFFFF);

    // Enable gating: outputs hold and the write is dropped.
    drive(1'b0, 1'b0, 1'b1, 3'd4, 3'd1, 3'd5, 16'hAAAA);
    chk("stall_hold_a", dataA, 16'h3333);
    chk("stall_hold_b", dataB, 16'hFFFF);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 3'd4, 16'h0);
    chk("stall_no_write", dataA, 16'h4444);

    // Collision on index 5 (still zero).
    drive(1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 3'd0, 16'h5555);
    chk("collision_same_edge", dataA, BYPASS ? 16'h5555 : 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd5, 3'd5, 16'h0);
    chk("collision_next_a", dataA, 16'h5555);
    chk("collision_next_b", dataB, 16'h5555);

    // Reset during a write discards it.
    drive(1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 3'd3, 16'h1234);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 3'd5, 16'h0);
    chk("reset_discards_write", dataA, 16'h0000);
    chk("reset_clears_reg5", dataB, 16'h0000);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(99) < 3), 1'($urandom_range(99) < 80), 1'($urandom_range(1)),
            3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
